// File: rtl/fft_frame_sched.sv
// Frame sequencer between FIR stream and 16-point FFT core: gathers 16 samples, pulses core_start, drains 16 bins.
// Latency: 16th accept -> core_start 1 cycle, core_valid -> first bin 1 cycle; both handshakes stall without loss.
module fft_frame_sched #(
  parameter int FRAMES  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fir_valid,
  input  logic [15:0]  fir_d,
  output logic         fir_ready,
  output logic         core_start,
  output logic [511:0] core_x,
  input  logic         core_valid,
  input  logic [511:0] core_re,
  input  logic [511:0] core_im,
  output logic         bin_valid,
  input  logic         bin_ready,
  output logic [3:0]   bin_idx,
  output logic [31:0]  bin_d,
  output logic [9:0]   frame_cnt,
  output logic         done,
  output logic         err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {COLLECT, START, WAIT, DRAIN, DONE} state_t;

  state_t          state;
  logic [4:0]      sample_cnt;
  logic [WD_W-1:0] wd;
  logic [511:0]    frame_buf;
  logic [511:0]    hold_dat;
  logic [511:0]    cap_dat;
  logic [15:0]     unused_core;
  logic            acc;
  logic            full_nxt;
  logic [31:0]     sample_q;

  // Only bits [23:8] of each Q16.16 bin are ever presented, so only those are held.
  for (genvar k = 0; k < 16; k++) begin : g_bin
    assign cap_dat[32*k +: 32] = {core_re[32*k+8 +: 16], core_im[32*k+8 +: 16]};
    assign unused_core[k] = ^{core_re[32*k+24 +: 8], core_re[32*k +: 8],
                              core_im[32*k+24 +: 8], core_im[32*k +: 8]};
  end

  assign fir_ready  = rst && (sample_cnt < 5'd16) && (state != START) && (state != DONE);
  assign acc        = fir_valid && fir_ready;
  // Full as seen after this cycle's accept, so a 16th sample can trigger START directly.
  assign full_nxt   = (sample_cnt == 5'd16) || (acc && (sample_cnt == 5'd15));
  assign sample_q   = {{8{fir_d[15]}}, fir_d, 8'h00};
  assign core_start = (state == START);
  assign bin_valid  = (state == DRAIN);
  assign done       = (state == DONE);
  assign core_x     = frame_buf;
  assign bin_d      = hold_dat[{bin_idx, 5'd0} +: 32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      sample_cnt <= '0;
      wd         <= '0;
      frame_buf  <= '0;
      hold_dat   <= '0;
      bin_idx    <= '0;
      frame_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      if (acc) begin
        frame_buf <= {sample_q, frame_buf[511:32]};
      end
      if (state == START) begin
        sample_cnt <= '0;
      end else if (acc) begin
        sample_cnt <= sample_cnt + 5'd1;
      end

      case (state)
        COLLECT: begin
          if (full_nxt) state <= START;
        end
        START: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Watchdog expires after TIMEOUT full cycles in WAIT.
          if (core_valid) begin
            hold_dat <= cap_dat;
            bin_idx  <= '0;
            state    <= DRAIN;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        DRAIN: begin
          if (bin_ready) begin
            bin_idx <= bin_idx + 4'd1;
            if (bin_idx == 4'd15) begin
              frame_cnt <= frame_cnt + 10'd1;
              if (frame_cnt == 10'(FRAMES - 1)) state <= DONE;
              else if (full_nxt)                state <= START;
              else                              state <= COLLECT;
            end
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with a 5-cycle FFT core model (re[k]=k<<16, im=0).
module tb_fft_frame_sched;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         fir_valid;
  logic [15:0]  fir_d;
  logic         fir_ready;
  logic         core_start;
  logic [511:0] core_x;
  logic         core_valid;
  logic [511:0] core_re;
  logic [511:0] core_im;
  logic         bin_valid;
  logic         bin_ready;
  logic [3:0]   bin_idx;
  logic [31:0]  bin_d;
  logic [9:0]   frame_cnt;
  logic         done;
  logic         err;

  logic         spur;
  logic         core_en;
  logic [4:0]   pipe = '0;
  logic [15:0]  tbl [0:15];

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int acc_cnt = 0, last_acc = 0, start_n = 0, cv_n = 0, bv_n = 0, bin_n = 0;
  int           st_cyc  [0:31];
  int           st_last [0:31];
  int           st_accn [0:31];
  logic [511:0] st_x    [0:31];
  int           cv_cyc  [0:31];
  logic [3:0]   log_idx [0:255];
  logic [31:0]  log_d   [0:255];
  int           log_cyc [0:255];

  fft_frame_sched #(.FRAMES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d), .fir_ready(fir_ready),
    .core_start(core_start), .core_x(core_x), .core_valid(core_valid),
    .core_re(core_re), .core_im(core_im), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_idx(bin_idx), .bin_d(bin_d), .frame_cnt(frame_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FFT core model: result pulse 5 cycles after the start pulse.
  always @(posedge clk) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[3:0], core_start & core_en};
  end
  assign core_valid = pipe[4] | spur;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (fir_valid && fir_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
    if (core_start && start_n < 32) begin
      st_cyc[start_n]  <= cyc;
      st_last[start_n] <= last_acc;
      st_accn[start_n] <= acc_cnt;
      st_x[start_n]    <= core_x;
      start_n          <= start_n + 1;
    end
    if (core_valid && cv_n < 32) begin
      cv_cyc[cv_n] <= cyc;
      cv_n         <= cv_n + 1;
    end
    if (bin_valid) bv_n <= bv_n + 1;
    if (bin_valid && bin_ready && bin_n < 256) begin
      log_idx[bin_n] <= bin_idx;
      log_d[bin_n]   <= bin_d;
      log_cyc[bin_n] <= cyc;
      bin_n          <= bin_n + 1;
    end
  end

  task automatic apply_reset;
    rst = 1'b0; fir_valid = 1'b0; bin_ready = 1'b0; spur = 1'b0; core_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    fir_valid = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (fir_ready !== 1'b0) begin failures++; $display("FAIL rst_fir_ready got %b want 0", fir_ready); end
    checks++; if (bin_valid !== 1'b0) begin failures++; $display("FAIL rst_bin_valid got %b want 0", bin_valid); end
    checks++; if (core_start !== 1'b0) begin failures++; $display("FAIL rst_core_start got %b want 0", core_start); end
    checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL rst_done_err got %b want 00", {done, err}); end
    checks++; if (frame_cnt !== 10'd0) begin failures++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (bin_idx !== 4'd0) begin failures++; $display("FAIL rst_bin_idx got %0d want 0", bin_idx); end
    checks++; if (core_x !== 512'd0) begin failures++; $display("FAIL rst_core_x got %h want 0", core_x[31:0]); end
    checks++; if (bin_d !== 32'd0) begin failures++; $display("FAIL rst_bin_d got %h want 0", bin_d); end
    @(posedge clk); #1 rst = 1'b1; fir_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (fir_ready !== 1'b1) begin failures++; $display("FAIL post_rst_fir_ready got %b want 1", fir_ready); end
  endtask

  task automatic test_basic;
    int n0, s0, c0;
    apply_reset();
    n0 = bin_n; s0 = start_n; c0 = cv_n;
    fir_d = 16'h0100; fir_valid = 1'b1; bin_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin @(negedge clk); #1; end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (st_cyc[s0] - st_last[s0] != 1) begin failures++; $display("FAIL basic_start_latency got %0d want 1", st_cyc[s0] - st_last[s0]); end
    checks++; if (st_x[s0][31:0] !== 32'h00010000) begin failures++; $display("FAIL basic_core_x0 got %h want 00010000", st_x[s0][31:0]); end
    checks++; if (st_x[s0][511:480] !== 32'h00010000) begin failures++; $display("FAIL basic_core_x15 got %h want 00010000", st_x[s0][511:480]); end
    checks++; if (bin_n - n0 != 32) begin failures++; $display("FAIL basic_bin_count got %0d want 32", bin_n - n0); end
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (log_idx[n0+j] !== 4'(j % 16) || log_d[n0+j] !== (32'(j % 16) << 24)) begin
        failures++; $display("FAIL basic_bin%0d got idx=%0d d=%h want idx=%0d d=%h", j, log_idx[n0+j], log_d[n0+j], j % 16, 32'(j % 16) << 24);
      end
    end
    checks++; if (log_cyc[n0+15] - log_cyc[n0] != 15) begin failures++; $display("FAIL basic_bin_span got %0d want 15", log_cyc[n0+15] - log_cyc[n0]); end
    checks++; if (log_cyc[n0] - cv_cyc[c0] != 1) begin failures++; $display("FAIL basic_valid_to_bin got %0d want 1", log_cyc[n0] - cv_cyc[c0]); end
    checks++; if (frame_cnt !== 10'd2) begin failures++; $display("FAIL basic_frame_cnt got %0d want 2", frame_cnt); end
    checks++; if (fir_ready !== 1'b0) begin failures++; $display("FAIL basic_done_fir_ready got %b want 0", fir_ready); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got %b want 0", err); end
  endtask

  task automatic test_backpressure;
    int n0, s0;
    logic pv, pr;
    logic [3:0] pidx;
    logic [31:0] pd;
    apply_reset();
    n0 = bin_n; s0 = start_n;
    fir_d = 16'h0100; fir_valid = 1'b1; bin_ready = 1'b0;
    pv = 1'b0; pr = 1'b0; pidx = '0; pd = '0;
    for (int i = 0; i < 400 && frame_cnt != 10'd1; i++) begin
      @(negedge clk); #1;
      if (frame_cnt == 10'd1) break;
      if (pv && !pr) begin
        checks++;
        if (bin_valid !== 1'b1 || bin_idx !== pidx || bin_d !== pd) begin
          failures++; $display("FAIL bp_hold got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h", bin_valid, bin_idx, bin_d, pidx, pd);
        end
      end
      if (bin_valid && bin_ready && bin_idx == 4'd15) begin
        checks++; if (fir_ready !== 1'b0) begin failures++; $display("FAIL bp_full_fir_ready got %b want 0", fir_ready); end
      end
      pv = bin_valid; pr = bin_ready; pidx = bin_idx; pd = bin_d;
      @(posedge clk); #1 bin_ready = ~bin_ready;
    end
    checks++; if (frame_cnt !== 10'd1) begin failures++; $display("FAIL bp_timeout frame_cnt got %0d want 1", frame_cnt); end
    checks++; if (core_start !== 1'b1) begin failures++; $display("FAIL bp_start_after_drain got %b want 1", core_start); end
    checks++; if (bin_n - n0 != 16) begin failures++; $display("FAIL bp_transfers got %0d want 16", bin_n - n0); end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (log_idx[n0+j] !== 4'(j)) begin failures++; $display("FAIL bp_order%0d got %0d want %0d", j, log_idx[n0+j], j); end
    end
    checks++; if (acc_cnt - st_accn[s0] != 16) begin failures++; $display("FAIL bp_collect got %0d want 16", acc_cnt - st_accn[s0]); end
  endtask

  task automatic test_fir_gaps;
    int a0, s0, k;
    logic [31:0] exp_w;
    apply_reset();
    a0 = acc_cnt; s0 = start_n; k = 0;
    bin_ready = 1'b1;
    for (int i = 0; i < 300 && start_n == s0; i++) begin
      fir_valid = (k < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      fir_d = tbl[(k < 16) ? k : 0];
      @(negedge clk); #1;
      if (fir_valid && fir_ready) k++;
      @(posedge clk); #1;
    end
    fir_valid = 1'b0;
    checks++; if (start_n == s0) begin failures++; $display("FAIL gaps_start_timeout got none want core_start"); end
    checks++; if (st_accn[s0] - a0 != 16) begin failures++; $display("FAIL gaps_accepts got %0d want 16", st_accn[s0] - a0); end
    for (int j = 0; j < 16; j++) begin
      exp_w = {{8{tbl[j][15]}}, tbl[j], 8'h00};
      checks++;
      if (st_x[s0][32*j +: 32] !== exp_w) begin failures++; $display("FAIL gaps_word%0d got %h want %h", j, st_x[s0][32*j +: 32], exp_w); end
    end
    checks++; if (st_x[s0][127:96] !== 32'hFFFF0000) begin failures++; $display("FAIL gaps_negative got %h want FFFF0000", st_x[s0][127:96]); end
  endtask

  task automatic test_timeout;
    int s0, b0;
    apply_reset();
    core_en = 1'b0;
    s0 = start_n; b0 = bv_n;
    fir_d = 16'h0100; fir_valid = 1'b1; bin_ready = 1'b1;
    for (int i = 0; i < 100 && start_n == s0; i++) begin @(negedge clk); #1; end
    checks++; if (start_n == s0) begin failures++; $display("FAIL to_start_timeout got none want core_start"); end
    for (int i = 0; i < 60 && !err; i++) begin @(negedge clk); #1; end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got %b want 1", err); end
    checks++; if (cyc - st_cyc[s0] != TO + 1) begin failures++; $display("FAIL to_latency got %0d want %0d", cyc - st_cyc[s0], TO + 1); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL to_done got %b want 1", done); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({err, done, fir_ready} !== 3'b110) begin failures++; $display("FAIL to_sticky got %b want 110", {err, done, fir_ready}); end
    checks++; if (bv_n != b0) begin failures++; $display("FAIL to_no_bins got %0d want 0", bv_n - b0); end
  endtask

  task automatic test_reset_mid_drain;
    int a0, s1;
    apply_reset();
    fir_d = 16'h0100; fir_valid = 1'b1; bin_ready = 1'b1;
    for (int i = 0; i < 300 && !(frame_cnt == 10'd1 && bin_valid && bin_idx == 4'd7); i++) begin @(negedge clk); #1; end
    checks++; if (!(frame_cnt == 10'd1 && bin_valid && bin_idx == 4'd7)) begin failures++; $display("FAIL mid_reach_bin7 got cnt=%0d idx=%0d want cnt=1 idx=7", frame_cnt, bin_idx); end
    rst = 1'b0;
    #1;
    checks++; if ({bin_valid, fir_ready} !== 2'b00) begin failures++; $display("FAIL mid_async_drop got %b want 00", {bin_valid, fir_ready}); end
    checks++; if (frame_cnt !== 10'd0) begin failures++; $display("FAIL mid_frame_cnt got %0d want 0", frame_cnt); end
    @(posedge clk); #1;
    rst = 1'b1; fir_d = 16'h0200;
    a0 = acc_cnt; s1 = start_n;
    for (int i = 0; i < 100 && start_n == s1; i++) begin @(negedge clk); #1; end
    checks++; if (start_n == s1) begin failures++; $display("FAIL mid_restart_timeout got none want core_start"); end
    checks++; if (st_accn[s1] - a0 != 16) begin failures++; $display("FAIL mid_fresh_count got %0d want 16", st_accn[s1] - a0); end
    checks++; if (st_x[s1][31:0] !== 32'h00020000) begin failures++; $display("FAIL mid_fresh_word0 got %h want 00020000", st_x[s1][31:0]); end
  endtask

  task automatic test_spurious_valid;
    int b0, c0;
    apply_reset();
    fir_valid = 1'b0; bin_ready = 1'b1;
    b0 = bv_n; c0 = cv_n;
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (cv_n - c0 != 1) begin failures++; $display("FAIL spur_pulse_seen got %0d want 1", cv_n - c0); end
    checks++; if (bv_n != b0) begin failures++; $display("FAIL spur_no_bins got %0d want 0", bv_n - b0); end
    checks++; if ({core_start, done, fir_ready} !== 3'b001) begin failures++; $display("FAIL spur_state got %b want 001", {core_start, done, fir_ready}); end
    checks++; if (bin_d !== 32'd0) begin failures++; $display("FAIL spur_no_capture got %h want 0", bin_d); end
  endtask

  initial begin
    rst = 1'b0; fir_valid = 1'b0; fir_d = '0; bin_ready = 1'b0; spur = 1'b0; core_en = 1'b1;
    core_im = '0;
    for (int k = 0; k < 16; k++) core_re[32*k +: 32] = 32'(k) << 16;
    for (int k = 0; k < 16; k++) tbl[k] = 16'h1000 + 16'(k);
    tbl[3] = 16'hFF00;
    tbl[9] = 16'h8001;
    test_reset();
    test_basic();
    test_backpressure();
    test_fir_gaps();
    test_timeout();
    test_reset_mid_drain();
    test_spurious_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
